rf_op_sequencer: RTL and testbench

RF_OP_SEQUENCER -- requirements
Module: rf_op_sequencer

---
 rtl/rf_op_sequencer.sv | 132 +++++++++++++
 tb/tb_rf_op_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_op_sequencer.sv
// Four-phase register-file operation sequencer: accept a command, read two
// operands, execute one 8-bit ALU op, write the result back.
module rf_op_sequencer (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [2:0] cmd_rd,
    input  logic [2:0] cmd_rs,
    input  logic [2:0] cmd_rt,
    input  logic [7:0] cmd_imm,
    output logic [2:0] RX,
    output logic [2:0] RY,
    input  logic [7:0] busX,
    input  logic [7:0] busY,
    output logic       WEN,
    output logic [2:0] RW,
    output logic [7:0] busW,
    output logic       done,
    output logic [7:0] result,
    output logic       carry
);
    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both 1; cmd_ready is high only in IDLE and out of reset,
    // and the requester holds cmd_valid and the fields until that edge.

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_LI   = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    state_t     state;
    state_t     state_next;
    logic [2:0] op_q;
    logic [7:0] imm_q;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [7:0] alu_res;
    logic       alu_carry;
    logic [8:0] sum;

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        WEN        = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = ~Rst;
                if (cmd_valid && !Rst) state_next = READ;
            end
            READ: state_next = EXEC;
            EXEC: state_next = WB;
            WB: begin
                // Gated by reset so a write is never issued while reset is held.
                WEN        = ~Rst;
                done       = ~Rst;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sum       = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = 8'd0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:  begin alu_res = sum[7:0]; alu_carry = sum[8]; end
            OP_SUB:  begin alu_res = op_a - op_b; alu_carry = (op_a < op_b); end
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLTU: alu_res = {7'd0, (op_a < op_b)};
            OP_LI:   alu_res = imm_q;
            OP_SHL:  alu_res = {op_a[6:0], 1'b0};
            default: alu_res = 8'd0;
        endcase
    end

    // RX/RY/RW are loaded at the accept edge, so they present the latched
    // addresses from READ onward and hold them until the next command.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            op_q   <= 3'd0;
            imm_q  <= 8'd0;
            op_a   <= 8'd0;
            op_b   <= 8'd0;
            RX     <= 3'd0;
            RY     <= 3'd0;
            RW     <= 3'd0;
            busW   <= 8'd0;
            result <= 8'd0;
            carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        imm_q <= cmd_imm;
                        RX    <= cmd_rs;
                        RY    <= cmd_rt;
                        RW    <= cmd_rd;
                    end
                end
                READ: begin
                    op_a <= busX;
                    op_b <= busY;
                end
                EXEC: begin
                    busW <= alu_res;
                    if (op_q == OP_ADD || op_q == OP_SUB) carry <= alu_carry;
                end
                WB: result <= busW;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed and random checks of rf_op_sequencer against an arithmetic
// reference model, with an 8-entry register file around the DUT.
module tb_rf_op_sequencer;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_rs;
    logic [2:0] cmd_rt;
    logic [7:0] cmd_imm;
    logic [2:0] RX;
    logic [2:0] RY;
    logic [7:0] busX;
    logic [7:0] busY;
    logic       WEN;
    logic [2:0] RW;
    logic [7:0] busW;
    logic       done;
    logic [7:0] result;
    logic       carry;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    // Reference state: register contents and the last result/carry.
    int ref_rf[8];
    int exp_result;
    int exp_carry;

    logic [7:0] rf [8] = '{default: 8'd0};

    always #5 Clk = ~Clk;

    rf_op_sequencer dut (
        .Clk(Clk), .Rst(Rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt),
        .cmd_imm(cmd_imm), .RX(RX), .RY(RY), .busX(busX), .busY(busY),
        .WEN(WEN), .RW(RW), .busW(busW), .done(done), .result(result),
        .carry(carry)
    );

    assign busX = rf[RX];
    assign busY = rf[RY];

    // r0 discards writes, so it always reads zero.
    always @(posedge Clk) begin
        if (WEN === 1'b1 && RW != 3'd0) rf[RW] <= busW;
    end

    always @(posedge Clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_alu(input int op, input int a, input int b, input int imm,
                                    output int res, output int c, output bit c_upd);
        c = 0;
        c_upd = (op == 0 || op == 1);
        case (op)
            0: begin res = (a + b) % 256; c = (a + b > 255) ? 1 : 0; end
            1: begin res = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (a < b) ? 1 : 0;
            6: res = imm;
            default: res = (a * 2) % 256;
        endcase
    endfunction

    function automatic void ref_exec(input int op, input int rd, input int rs, input int rt,
                                     input int imm, output int res);
        int c;
        bit cu;
        ref_alu(op, ref_rf[rs], ref_rf[rt], imm, res, c, cu);
        if (rd != 0) ref_rf[rd] = res;
        exp_result = res;
        if (cu) exp_carry = c;
    endfunction

    // Issues one command from a negedge and follows it to the next IDLE negedge.
    task automatic issue(input int op, input int rd, input int rs, input int rt, input int imm);
        int k;
        int r;
        k = 0;
        while (cmd_ready !== 1'b1 && k < 16) begin
            @(negedge Clk);
            k++;
        end
        check("accept_ready", cmd_ready, 1);
        cmd_op = op[2:0]; cmd_rd = rd[2:0]; cmd_rs = rs[2:0]; cmd_rt = rt[2:0];
        cmd_imm = imm[7:0];
        cmd_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        cmd_valid = 1'b0;
        check("read_rx", RX, rs);
        check("read_ry", RY, rt);
        check("read_ready", cmd_ready, 0);
        check("read_wen", WEN, 0);
        ref_exec(op, rd, rs, rt, imm, r);
        @(negedge Clk);
        check("exec_wen", WEN, 0);
        check("exec_done", done, 0);
        @(negedge Clk);
        check("wb_wen", WEN, 1);
        check("wb_done", done, 1);
        check("wb_rw", RW, rd);
        check("wb_busw", busW, r);
        @(negedge Clk);
        check("idle_result", result, exp_result);
        check("idle_carry", carry, exp_carry);
        check("idle_ready", cmd_ready, 1);
        check("idle_wen", WEN, 0);
    endtask

    initial begin
        int d0;
        int k;
        int r;
        time t_acc[3];
        int s_op[3];
        int s_imm[3];

        for (int i = 0; i < 8; i++) ref_rf[i] = 0;
        exp_result = 0;
        exp_carry  = 0;

        // Reset with a command already offered: it must not be taken.
        Rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_op = 3'd6; cmd_rd = 3'd1; cmd_rs = 3'd0; cmd_rt = 3'd0; cmd_imm = 8'd9;
        repeat (3) @(negedge Clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_wen", WEN, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_carry", carry, 0);
        check("rst_rx", RX, 0);
        check("rst_ry", RY, 0);
        check("rst_rw", RW, 0);
        check("rst_busw", busW, 0);
        cmd_valid = 1'b0;
        Rst = 1'b0;
        @(negedge Clk);
        check("post_rst_ready", cmd_ready, 1);
        check("post_rst_rf1", rf[1], 0);

        // Two loads: exactly two done pulses.
        d0 = done_cnt;
        issue(6, 1, 0, 0, 100);
        issue(6, 2, 0, 0, 50);
        check("li_done_count", done_cnt - d0, 2);
        check("li_r1", rf[1], 100);
        check("li_r2", rf[2], 50);

        // ADD/SUB with carry and borrow.
        issue(6, 1, 0, 0, 200);
        issue(6, 2, 0, 0, 100);
        issue(0, 3, 1, 2, 0);
        check("add_const", result, 44);
        check("add_carry_const", carry, 1);
        issue(1, 4, 2, 1, 0);
        check("sub_const", result, 156);
        check("sub_borrow_const", carry, 1);

        // SLTU and SHL; carry must stay untouched by non-arithmetic ops.
        issue(6, 2, 0, 0, 50);
        issue(5, 6, 2, 1, 0);
        check("sltu_const", result, 1);
        issue(7, 7, 1, 0, 0);
        check("shl_const", result, 144);
        check("shl_keeps_carry", carry, 1);

        // Write to r0 is issued but reads back as zero.
        issue(6, 0, 0, 0, 77);
        issue(2, 5, 0, 1, 0);
        check("r0_and_const", result, 0);

        // Reset in EXEC: command discarded, no write-back.
        cmd_op = 3'd6; cmd_rd = 3'd3; cmd_rs = 3'd0; cmd_rt = 3'd0; cmd_imm = 8'd123;
        cmd_valid = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        cmd_valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        d0 = done_cnt;
        @(negedge Clk);
        check("midrst_wen", WEN, 0);
        check("midrst_ready", cmd_ready, 0);
        check("midrst_result", result, 0);
        check("midrst_carry", carry, 0);
        check("midrst_busw", busW, 0);
        @(negedge Clk);
        Rst = 1'b0;
        #1;
        check("midrst_ready_after", cmd_ready, 1);
        @(negedge Clk);
        check("midrst_no_wen", WEN, 0);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_r3_kept", rf[3], ref_rf[3]);
        exp_result = 0;
        exp_carry  = 0;

        // cmd_valid held high across a dependent chain.
        s_op = '{6, 0, 0};
        s_imm = '{5, 0, 0};
        for (int i = 0; i < 3; i++) begin
            cmd_op = s_op[i][2:0]; cmd_rd = 3'd1; cmd_rs = 3'd1; cmd_rt = 3'd1;
            cmd_imm = s_imm[i][7:0];
            cmd_valid = 1'b1;
            k = 0;
            while (cmd_ready !== 1'b1 && k < 16) begin
                @(negedge Clk);
                k++;
            end
            check("stream_ready", cmd_ready, 1);
            @(posedge Clk);
            t_acc[i] = $time;
            ref_exec(s_op[i], 1, 1, 1, s_imm[i], r);
            #1;
        end
        cmd_valid = 1'b0;
        repeat (4) @(negedge Clk);
        check("stream_gap1", int'(t_acc[1] - t_acc[0]), 40);
        check("stream_gap2", int'(t_acc[2] - t_acc[1]), 40);
        check("stream_r1", rf[1], ref_rf[1]);
        check("stream_r1_const", rf[1], 20);
        check("stream_result", result, 20);

        // Random commands against the reference model.
        for (int i = 0; i < 24; i++) begin
            issue($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 255));
        end
        for (int i = 0; i < 8; i++) check("final_rf", rf[i], ref_rf[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
